// File: rtl/mem_arb.sv
// mem_arb: arbitrates a pipeline M-stage port and a bridge port onto one fixed-latency single-port memory.
// Ports:
//   clk, reset (async, active-low)
//   m_req/m_we/m_be/m_addr/m_wdata -> m_ack, m_rdata, m_stall   pipeline M-stage port
//   b_req/b_we/b_be/b_addr/b_wdata -> b_ack, b_rdata            bridge (debug/DMA) port
//   mem_en/mem_we/mem_be/mem_addr/mem_wdata, mem_rdata           memory command / read data
module mem_arb #(
  parameter int LAT    = 2,
  parameter int STARVE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_req,
  input  logic        m_we,
  input  logic [3:0]  m_be,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  output logic        m_ack,
  output logic [31:0] m_rdata,
  output logic        m_stall,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [3:0]  b_be,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_ack,
  output logic [31:0] b_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t      state, state_nx;
  logic [2:0]  starve_cnt;
  logic [3:0]  wait_cnt;
  logic [31:0] rdata_q;
  logic        owner;
  logic        we_q;
  logic [3:0]  be_q;
  logic        any_req;
  logic        grant_b;
  assign any_req = m_req | b_req;
  // bridge wins when M is idle or M has used up its tolerated run of grants
  assign grant_b = b_req & (~m_req | starve_cnt == 3'(STARVE));
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  always_comb
    state_nx = state == IDLE  ? (any_req ? ISSUE : IDLE) :
               state == ISSUE ? WAIT :
               state == WAIT  ? (wait_cnt == 4'd0 ? DONE : WAIT) : IDLE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      starve_cnt <= 3'd0;
      wait_cnt   <= 4'd0;
      rdata_q    <= 32'd0;
      owner      <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= 4'd0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
    end else begin
      if (state == IDLE) begin
        starve_cnt <= (~b_req | grant_b) ? 3'd0 :
                      starve_cnt == 3'(STARVE) ? starve_cnt : starve_cnt + 3'd1;
        if (any_req) begin
          owner     <= grant_b;
          we_q      <= grant_b ? b_we    : m_we;
          be_q      <= grant_b ? b_be    : m_be;
          mem_addr  <= grant_b ? b_addr  : m_addr;
          mem_wdata <= grant_b ? b_wdata : m_wdata;
        end
      end
      if (state == ISSUE) wait_cnt <= 4'(LAT - 1);
      if (state == WAIT && wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
      // stores return zero data so the owner's rdata is clean on a write ack
      if (state == WAIT && wait_cnt == 4'd0) rdata_q <= we_q ? 32'd0 : mem_rdata;
    end
  always_comb begin
    mem_en  = state == ISSUE;
    mem_we  = mem_en & we_q;
    mem_be  = mem_en ? be_q : 4'd0;
    m_ack   = state == DONE & ~owner;
    b_ack   = state == DONE & owner;
    m_rdata = m_ack ? rdata_q : 32'd0;
    b_rdata = b_ack ? rdata_q : 32'd0;
    m_stall = m_req & ~m_ack;
  end
endmodule

// File: tb/tb_mem_arb.sv
module tb_mem_arb;
  localparam int LAT = 2;
  localparam int STARVE = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic m_req = 1'b0, m_we = 1'b0;
  logic [3:0] m_be = 4'd0;
  logic [31:0] m_addr = 32'd0, m_wdata = 32'd0;
  logic b_req = 1'b0, b_we = 1'b0;
  logic [3:0] b_be = 4'd0;
  logic [31:0] b_addr = 32'd0, b_wdata = 32'd0;
  logic m_ack, m_stall, b_ack, mem_en, mem_we;
  logic [31:0] m_rdata, b_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_be;
  logic s1_m_ack, s1_m_stall, s1_b_ack, s1_mem_en, s1_mem_we;
  logic [31:0] s1_m_rdata, s1_b_rdata, s1_mem_addr, s1_mem_wdata, s1_mem_rdata;
  logic [3:0] s1_mem_be;
  logic s15_m_ack, s15_m_stall, s15_b_ack, s15_mem_en, s15_mem_we;
  logic [31:0] s15_m_rdata, s15_b_rdata, s15_mem_addr, s15_mem_wdata, s15_mem_rdata;
  logic [3:0] s15_mem_be;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;

  mem_arb #(.LAT(LAT), .STARVE(STARVE)) dut (
    .clk(clk), .reset(reset),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .m_stall(m_stall),
    .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  mem_arb #(.LAT(1), .STARVE(STARVE)) dut1 (
    .clk(clk), .reset(reset),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(s1_m_ack), .m_rdata(s1_m_rdata), .m_stall(s1_m_stall),
    .b_req(1'b0), .b_we(1'b0), .b_be(4'd0), .b_addr(32'd0), .b_wdata(32'd0),
    .b_ack(s1_b_ack), .b_rdata(s1_b_rdata),
    .mem_en(s1_mem_en), .mem_we(s1_mem_we), .mem_be(s1_mem_be), .mem_addr(s1_mem_addr),
    .mem_wdata(s1_mem_wdata), .mem_rdata(s1_mem_rdata));

  mem_arb #(.LAT(15), .STARVE(STARVE)) dut15 (
    .clk(clk), .reset(reset),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(s15_m_ack), .m_rdata(s15_m_rdata), .m_stall(s15_m_stall),
    .b_req(1'b0), .b_we(1'b0), .b_be(4'd0), .b_addr(32'd0), .b_wdata(32'd0),
    .b_ack(s15_b_ack), .b_rdata(s15_b_rdata),
    .mem_en(s15_mem_en), .mem_we(s15_mem_we), .mem_be(s15_mem_be), .mem_addr(s15_mem_addr),
    .mem_wdata(s15_mem_wdata), .mem_rdata(s15_mem_rdata));

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a == 32'h100 ? 32'hDEADBEEF : (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // behavioural memories: read data is valid only in the cycle exactly N cycles after the mem_en cycle
  logic [32:0] sr [0:15];
  logic [32:0] sr1 [0:15];
  logic [32:0] sr15 [0:15];
  always @(posedge clk) begin
    sr[0] <= {mem_en & ~mem_we, memfn(mem_addr)};
    for (int i = 1; i < 16; i++) sr[i] <= sr[i-1];
  end
  always @(posedge clk) begin
    sr1[0] <= {s1_mem_en & ~s1_mem_we, memfn(s1_mem_addr)};
    for (int j = 1; j < 16; j++) sr1[j] <= sr1[j-1];
  end
  always @(posedge clk) begin
    sr15[0] <= {s15_mem_en & ~s15_mem_we, memfn(s15_mem_addr)};
    for (int k = 1; k < 16; k++) sr15[k] <= sr15[k-1];
  end
  assign mem_rdata     = sr[LAT-1][32] ? sr[LAT-1][31:0] : 32'hBAD0BAD0;
  assign s1_mem_rdata  = sr1[0][32] ? sr1[0][31:0] : 32'hBAD0BAD0;
  assign s15_mem_rdata = sr15[14][32] ? sr15[14][31:0] : 32'hBAD0BAD0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    m_req = 1'b1; m_we = 1'b0; m_be = 4'hF; m_addr = 32'h40;
    b_req = 1'b1; b_we = 1'b1; b_be = 4'hF; b_addr = 32'h8000_0040; b_wdata = 32'h55;
    repeat (3) tick;
    checks++;
    if ({mem_en, mem_we, mem_be, mem_addr, mem_wdata, m_ack, b_ack, m_rdata, b_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0",
               {mem_en, mem_we, mem_be, mem_addr, mem_wdata, m_ack, b_ack, m_rdata, b_rdata});
    end
    checks++;
    if (m_stall !== 1'b1) begin failures++; $display("FAIL reset_stall_req got=%b exp=1", m_stall); end
    m_req = 1'b0; b_req = 1'b0; b_we = 1'b0;
    #1;
    checks++;
    if (m_stall !== 1'b0) begin failures++; $display("FAIL reset_stall_idle got=%b exp=0", m_stall); end
    m_req = 1'b1;
    #2 reset = 1'b1;
    tick;
    checks++;
    if ({mem_en, mem_addr} !== {1'b1, 32'h40}) begin
      failures++; $display("FAIL first_grant got=%h exp=%h", {mem_en, mem_addr}, {1'b1, 32'h40});
    end
    for (int n = 2; n <= LAT + 2; n++) tick;
    checks++;
    if ({m_ack, m_rdata} !== {1'b1, memfn(32'h40)}) begin
      failures++; $display("FAIL first_ack got=%h exp=%h", {m_ack, m_rdata}, {1'b1, memfn(32'h40)});
    end
    m_req = 1'b0;
    tick;
  endtask

  task automatic test_latency;
    int a1, a2, a15;
    logic [31:0] addr;
    a1 = -1; a2 = -1; a15 = -1;
    m_req = 1'b0;
    repeat (20) tick;
    addr = $urandom() & 32'h7FFF_FFFC;
    m_req = 1'b1; m_we = 1'b0; m_be = 4'hF; m_addr = addr;
    for (int n = 1; n <= 20; n++) begin
      tick;
      if (a1 < 0 && s1_m_ack === 1'b1) begin
        a1 = n; checks++;
        if (s1_m_rdata !== memfn(addr)) begin failures++; $display("FAIL lat1_rdata got=%h exp=%h", s1_m_rdata, memfn(addr)); end
      end
      if (a2 < 0 && m_ack === 1'b1) begin
        a2 = n; checks++;
        if (m_rdata !== memfn(addr)) begin failures++; $display("FAIL lat2_rdata got=%h exp=%h", m_rdata, memfn(addr)); end
      end
      if (a15 < 0 && s15_m_ack === 1'b1) begin
        a15 = n; checks++;
        if (s15_m_rdata !== memfn(addr)) begin failures++; $display("FAIL lat15_rdata got=%h exp=%h", s15_m_rdata, memfn(addr)); end
      end
      if (n == LAT + 2) m_req = 1'b0;
    end
    checks++;
    if (a1 != 3) begin failures++; $display("FAIL lat1_cycles got=%0d exp=3", a1); end
    checks++;
    if (a2 != LAT + 2) begin failures++; $display("FAIL lat2_cycles got=%0d exp=%0d", a2, LAT + 2); end
    checks++;
    if (a15 != 17) begin failures++; $display("FAIL lat15_cycles got=%0d exp=17", a15); end
    repeat (3) tick;
  endtask

  task automatic test_m_load;
    logic [31:0] addr, wdata, exp_rd;
    logic [3:0] be;
    logic we;
    for (int k = 0; k < 7; k++) begin
      addr = k == 0 ? 32'h100 : $urandom() & 32'h7FFF_FFFC;
      we = k == 0 ? 1'b0 : 1'($urandom() % 2);
      be = k == 0 ? 4'hF : 4'($urandom());
      wdata = $urandom();
      exp_rd = we ? 32'd0 : memfn(addr);
      m_req = 1'b1; m_we = we; m_be = be; m_addr = addr; m_wdata = wdata;
      for (int n = 1; n <= LAT + 2; n++) begin
        tick;
        if (n == 1) begin
          checks++;
          if ({mem_en, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, we, be, addr, wdata}) begin
            failures++; $display("FAIL m_issue got=%h exp=%h",
              {mem_en, mem_we, mem_be, mem_addr, mem_wdata}, {1'b1, we, be, addr, wdata});
          end
        end
        if (n < LAT + 2) begin
          checks++;
          if ({m_ack, m_stall} !== 2'b01) begin failures++; $display("FAIL m_wait n=%0d got=%b exp=01", n, {m_ack, m_stall}); end
        end else begin
          checks++;
          if ({m_ack, m_stall, b_ack, m_rdata, b_rdata} !== {3'b100, exp_rd, 32'd0}) begin
            failures++; $display("FAIL m_done got=%h exp=%h",
              {m_ack, m_stall, b_ack, m_rdata, b_rdata}, {3'b100, exp_rd, 32'd0});
          end
        end
      end
      m_req = 1'b0;
      tick;
      checks++;
      if ({m_ack, mem_en, mem_we, mem_be} !== 7'd0) begin
        failures++; $display("FAIL m_ack_pulse got=%b exp=0", {m_ack, mem_en, mem_we, mem_be});
      end
    end
  endtask

  task automatic test_b_store;
    logic [31:0] addr, wdata, exp_rd;
    logic [3:0] be;
    logic we;
    for (int k = 0; k < 6; k++) begin
      addr = k == 0 ? 32'h8000_0200 : $urandom() | 32'h8000_0000;
      we = k == 0 ? 1'b1 : 1'($urandom() % 2);
      be = k == 0 ? 4'b0011 : 4'($urandom());
      wdata = k == 0 ? 32'h1234 : $urandom();
      exp_rd = we ? 32'd0 : memfn(addr);
      b_req = 1'b1; b_we = we; b_be = be; b_addr = addr; b_wdata = wdata;
      for (int n = 1; n <= LAT + 2; n++) begin
        tick;
        if (n == 1) begin
          checks++;
          if ({mem_en, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, we, be, addr, wdata}) begin
            failures++; $display("FAIL b_issue got=%h exp=%h",
              {mem_en, mem_we, mem_be, mem_addr, mem_wdata}, {1'b1, we, be, addr, wdata});
          end
        end
        if (n < LAT + 2) begin
          checks++;
          if ({b_ack, m_ack} !== 2'b00) begin failures++; $display("FAIL b_wait n=%0d got=%b exp=00", n, {b_ack, m_ack}); end
        end else begin
          checks++;
          if ({b_ack, m_ack, m_stall, b_rdata, m_rdata} !== {3'b100, exp_rd, 32'd0}) begin
            failures++; $display("FAIL b_done got=%h exp=%h",
              {b_ack, m_ack, m_stall, b_rdata, m_rdata}, {3'b100, exp_rd, 32'd0});
          end
        end
      end
      b_req = 1'b0;
      tick;
      checks++;
      if ({b_ack, mem_en} !== 2'b00) begin failures++; $display("FAIL b_ack_pulse got=%b exp=00", {b_ack, mem_en}); end
    end
  endtask

  task automatic test_back_to_back;
    int ta, acks;
    ta = -1; acks = 0;
    m_req = 1'b1; m_we = 1'b0; m_be = 4'hF; m_addr = $urandom() & 32'h7FFF_FFFC;
    for (int t = 1; t <= 60 && acks < 5; t++) begin
      tick;
      if (mem_en === 1'b1 && ta >= 0) begin
        checks++;
        if (t - ta != 2) begin failures++; $display("FAIL b2b_gap got=%0d exp=2", t - ta); end
        ta = -1;
      end
      if (m_ack === 1'b1) begin
        checks++;
        if (m_rdata !== memfn(m_addr)) begin failures++; $display("FAIL b2b_rdata got=%h exp=%h", m_rdata, memfn(m_addr)); end
        ta = t; acks++;
        m_addr = $urandom() & 32'h7FFF_FFFC;
      end
    end
    checks++;
    if (acks != 5) begin failures++; $display("FAIL b2b_acks got=%0d exp=5", acks); end
    m_req = 1'b0;
    repeat (2) tick;
  endtask

  task automatic test_contention;
    int cnt;
    logic exp_b, found, we;
    logic [31:0] addr, wdata, exp_rd;
    logic [3:0] be;
    cnt = 0;
    m_req = 1'b1; m_we = 1'($urandom() % 2); m_be = 4'($urandom()); m_addr = $urandom() & 32'h7FFF_FFFC; m_wdata = $urandom();
    b_req = 1'b1; b_we = 1'($urandom() % 2); b_be = 4'($urandom()); b_addr = $urandom() | 32'h8000_0000; b_wdata = $urandom();
    for (int tx = 0; tx < 30; tx++) begin
      // bridge is owed the grant once M has taken STARVE grants in a row while it waited
      exp_b = b_req && (!m_req || cnt == STARVE);
      cnt = (exp_b || !b_req) ? 0 : (cnt == STARVE ? STARVE : cnt + 1);
      we = exp_b ? b_we : m_we;
      be = exp_b ? b_be : m_be;
      addr = exp_b ? b_addr : m_addr;
      wdata = exp_b ? b_wdata : m_wdata;
      exp_rd = we ? 32'd0 : memfn(addr);
      found = 1'b0;
      for (int w = 0; w < 6 && !found; w++) begin
        tick;
        found = mem_en;
      end
      checks++;
      if (found !== 1'b1) begin failures++; $display("FAIL contention_timeout tx=%0d got=%b exp=1", tx, found); break; end
      checks++;
      if ({mem_we, mem_be, mem_addr, mem_wdata} !== {we, be, addr, wdata}) begin
        failures++; $display("FAIL contention_grant tx=%0d got=%h exp=%h (bridge=%b)",
          tx, {mem_we, mem_be, mem_addr, mem_wdata}, {we, be, addr, wdata}, exp_b);
      end
      repeat (LAT + 1) tick;
      checks++;
      if ({m_ack, b_ack, m_rdata, b_rdata} !== (exp_b ? {2'b01, 32'd0, exp_rd} : {2'b10, exp_rd, 32'd0})) begin
        failures++; $display("FAIL contention_ack tx=%0d got=%h exp=%h", tx, {m_ack, b_ack, m_rdata, b_rdata},
          exp_b ? {2'b01, 32'd0, exp_rd} : {2'b10, exp_rd, 32'd0});
      end
      if (exp_b) begin
        b_req = tx < 10 || ($urandom() % 4 != 0);
        b_we = 1'($urandom() % 2); b_be = 4'($urandom()); b_addr = $urandom() | 32'h8000_0000; b_wdata = $urandom();
      end else begin
        m_req = tx < 10 || ($urandom() % 4 != 0);
        m_we = 1'($urandom() % 2); m_be = 4'($urandom()); m_addr = $urandom() & 32'h7FFF_FFFC; m_wdata = $urandom();
      end
      if (!m_req && !b_req) begin
        if ($urandom() % 2 == 0) m_req = 1'b1;
        else b_req = 1'b1;
      end
    end
    m_req = 1'b0; b_req = 1'b0;
    repeat (LAT + 4) tick;
  endtask

  task automatic test_reset_mid;
    logic [31:0] addr;
    addr = $urandom() & 32'h7FFF_FFFC;
    m_req = 1'b1; m_we = 1'b0; m_be = 4'hF; m_addr = addr;
    repeat (2) tick;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({mem_en, mem_we, mem_be, m_ack, b_ack, m_rdata, mem_addr, mem_wdata} !== '0) begin
      failures++; $display("FAIL midreset_outputs got=%h exp=0", {mem_en, mem_we, mem_be, m_ack, b_ack, m_rdata, mem_addr, mem_wdata});
    end
    checks++;
    if (m_stall !== 1'b1) begin failures++; $display("FAIL midreset_stall got=%b exp=1", m_stall); end
    repeat (3) begin
      tick;
      checks++;
      if ({m_ack, mem_en} !== 2'b00) begin failures++; $display("FAIL midreset_noack got=%b exp=00", {m_ack, mem_en}); end
    end
    #2 reset = 1'b1;
    for (int n = 1; n <= LAT + 2; n++) begin
      tick;
      if (n == 1) begin
        checks++;
        if ({mem_en, mem_addr} !== {1'b1, addr}) begin failures++; $display("FAIL restart_issue got=%h exp=%h", {mem_en, mem_addr}, {1'b1, addr}); end
      end
      if (n < LAT + 2) begin
        checks++;
        if (m_ack !== 1'b0) begin failures++; $display("FAIL restart_early_ack n=%0d got=%b exp=0", n, m_ack); end
      end else begin
        checks++;
        if ({m_ack, m_rdata} !== {1'b1, memfn(addr)}) begin failures++; $display("FAIL restart_ack got=%h exp=%h", {m_ack, m_rdata}, {1'b1, memfn(addr)}); end
      end
    end
    m_req = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_latency;
    test_m_load;
    test_b_store;
    test_back_to_back;
    test_contention;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter LAT, default 2, memory read latency in cycles from the mem_en cycle to mem_rdata valid (legal 1..15).
REQ-002 Parameter STARVE, default 4, consecutive M-port grants tolerated while b_req is pending (legal 1..7).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-low (reset=0 resets).
REQ-005 m_req  in  1  pipeline M-stage memory access request; held with m_we/m_be/m_addr/m_wdata stable until m_ack.
REQ-006 m_we  in  1  M-stage write (1) / read (0).
REQ-007 m_be  in  4  M-stage byte enables.
REQ-008 m_addr  in  32  M-stage byte address.
REQ-009 m_wdata  in  32  M-stage store data.
REQ-010 m_ack  out  1  one-cycle completion pulse, M port.
REQ-011 m_rdata  out  32  M-stage load data, valid while m_ack=1.
REQ-012 m_stall  out  1  pipeline hold request to the M stage.
REQ-013 b_req, b_we, b_be[3:0], b_addr[31:0], b_wdata[31:0]  in  bridge (debug/DMA) port; same rules as the M port.
REQ-014 b_ack  out  1, b_rdata  out  32  bridge completion pulse and load data.
REQ-015 mem_en  out  1, mem_we  out  1, mem_be  out  4, mem_addr  out  32, mem_wdata  out  32  registered single-port memory command.
REQ-016 mem_rdata  in  32  memory read data, valid exactly LAT cycles after the mem_en cycle.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE.
REQ-018 IDLE: with no request, stay in IDLE; otherwise grant one port, latch its command into the mem_* registers and the owner flag, and go to ISSUE.
REQ-019 Grant rule: the bridge wins if b_req=1 and (m_req=0 or starve_cnt==STARVE); otherwise the M port wins when m_req=1.
REQ-020 starve_cnt (3 bit) SHALL increment on each M grant while b_req=1, clear on a bridge grant or on any IDLE cycle with b_req=0, and saturate at STARVE.
REQ-021 ISSUE: mem_en=1 for exactly this one cycle, then go to WAIT with wait_cnt loaded with LAT-1.
REQ-022 WAIT: decrement wait_cnt each cycle; when wait_cnt==0, capture mem_rdata into rdata_q and go to DONE. Writes also traverse WAIT so that every access takes the same time.
REQ-023 DONE: pulse the owner's ack for one cycle, drive rdata_q on that owner's rdata (the other port's rdata stays 0), then go to IDLE.
REQ-024 Latency: request sampled at edge E0 in IDLE -> ack in cycle LAT+2 after E0 (4 cycles for LAT=2). A new grant is possible no earlier than the IDLE cycle after DONE.
REQ-025 m_stall = m_req & ~m_ack (combinational). With m_req=0, m_stall=0.
REQ-026 mem_en, mem_we and mem_be SHALL be 0 outside ISSUE. mem_addr and mem_wdata hold their last value.
REQ-027 A request dropped before its ack is a protocol violation. The granted access still completes and the ack is still pulsed.
REQ-028 Simultaneous m_req and b_req in IDLE with starve_cnt<STARVE -> M granted. The bridge waits until it is guaranteed a grant after at most STARVE M grants.

Reset
REQ-029 reset=0 SHALL immediately force IDLE, starve_cnt=0, wait_cnt=0, rdata_q=0, owner=M, and all mem_* outputs, m_ack, b_ack, m_rdata and b_rdata to 0, regardless of any access in flight.
REQ-030 The first grant after reset deassertion SHALL happen no earlier than the first rising edge with reset=1.
REQ-031 An access aborted by reset SHALL NOT produce an ack. Requesters re-issue it.

Verification
REQ-032 Single M load, LAT=2: m_req=1, m_addr=0x100, mem_rdata=0xDEADBEEF -> mem_en pulse 1 cycle after grant; m_ack and m_rdata=0xDEADBEEF 4 cycles after the sampling edge; m_stall=1 until then.
REQ-033 Bridge store: b_req=1, b_we=1, b_be=4'b0011, b_wdata=0x1234 -> mem_we=1 and mem_be=4'b0011 in ISSUE; b_ack 4 cycles later; b_rdata=0.
REQ-034 Contention: m_req and b_req both held continuously, STARVE=4 -> grant order M,M,M,M,B,M,...; b_ack after the 4th m_ack.
REQ-035 Back-to-back M requests -> next mem_en exactly 2 cycles after the previous m_ack (one IDLE cycle, then ISSUE).
REQ-036 reset=0 asserted mid-WAIT -> mem_en=0, no ack, state IDLE; after release, a held request restarts with full latency.
REQ-037 LAT=1 and LAT=15 builds -> ack at 3 and 17 cycles after the sampling edge, respectively.
